qspi_sram_controller: RTL and testbench

Host-side QSPI master that drives the external serial SRAM with single-byte 1S-4S-4S transactions. Read uses command 0xEB, write uses 0x38. It accepts byte requests on a valid/ready interface and generates sck, ss_n and the tri-state sio lines. It returns read data on a one-cycle response strobe. It sits between the design's memory-request logic and the chip's QSPI pads, and is the initiator counterpart of the SRAM behavioural model.

---
 rtl/qspi_sram_controller.sv | 198 +++++++++++++++++++
 tb/tb_qspi_sram_controller.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_sram_controller.sv
// QSPI master for single-byte 1S-4S-4S reads (0xEB) and writes (0x38) to a serial SRAM.
// sck runs at clk/2; every pad-facing output comes straight from a flop.
module qspi_sram_controller #(
    parameter logic [7:0] CMD_READ        = 8'hEB,
    parameter logic [7:0] CMD_WRITE       = 8'h38,
    parameter int         WAIT_CYCLES     = 4,
    parameter int         DESELECT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [23:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        sck,
    output logic        ss_n,
    output logic [3:0]  sio_out,
    output logic [3:0]  sio_oe,
    input  logic [3:0]  sio_in
);

    typedef enum logic [2:0] {
        IDLE, CMD, ADDR, DUMMY, WDATA, RDATA, DESELECT
    } state_t;

    localparam logic [4:0] WR_SLOTS     = 5'd16;
    localparam logic [4:0] RD_SLOTS     = 5'(16 + WAIT_CYCLES);
    localparam logic [4:0] RDATA_FIRST  = 5'(14 + WAIT_CYCLES);
    localparam logic [4:0] RDATA_LAST   = 5'(15 + WAIT_CYCLES);
    localparam logic [3:0] DESEL_LAST   = 4'(DESELECT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [4:0]  slot_q, slot_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        sck_q, sck_d;
    logic        ss_n_q, ss_n_d;
    logic [3:0]  sio_out_q, sio_out_d;
    logic [3:0]  sio_oe_q, sio_oe_d;
    logic        ready_q, ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [7:0]  rsp_rdata_q, rsp_rdata_d;
    logic [3:0]  hi_q, hi_d;
    logic        wr_q, wr_d;
    logic [23:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;

    logic [4:0]  slot_next;
    logic [7:0]  opcode;

    function automatic logic [3:0] addr_nibble(input logic [23:0] a, input logic [4:0] n);
        case (n)
            5'd8:    addr_nibble = a[23:20];
            5'd9:    addr_nibble = a[19:16];
            5'd10:   addr_nibble = a[15:12];
            5'd11:   addr_nibble = a[11:8];
            5'd12:   addr_nibble = a[7:4];
            default: addr_nibble = a[3:0];
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        cnt_d       = cnt_q;
        sck_d       = sck_q;
        ss_n_d      = ss_n_q;
        sio_out_d   = sio_out_q;
        sio_oe_d    = sio_oe_q;
        ready_d     = ready_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        hi_d        = hi_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        slot_next   = slot_q + 5'd1;
        opcode      = wr_q ? CMD_WRITE : CMD_READ;

        case (state_q)
            DESELECT: begin
                sck_d     = 1'b0;
                ss_n_d    = 1'b1;
                sio_oe_d  = 4'b0000;
                sio_out_d = 4'b0000;
                if (cnt_q == DESEL_LAST) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            IDLE: begin
                if (req_valid) begin
                    ready_d   = 1'b0;
                    wr_d      = req_write;
                    addr_d    = req_addr;
                    wdata_d   = req_wdata;
                    state_d   = CMD;
                    slot_d    = 5'd0;
                    ss_n_d    = 1'b0;
                    sck_d     = 1'b0;
                    sio_out_d = {3'b000, req_write ? CMD_WRITE[7] : CMD_READ[7]};
                    sio_oe_d  = 4'b0001;
                end
            end
            default: begin
                if (!sck_q) begin
                    sck_d = 1'b1;
                end else begin
                    // End of a high phase: sample read nibbles, then set up the next slot's low phase.
                    sck_d  = 1'b0;
                    slot_d = slot_next;
                    if (state_q == RDATA) begin
                        if (slot_q == RDATA_LAST) begin
                            rsp_valid_d = 1'b1;
                            rsp_rdata_d = {hi_q, sio_in};
                        end else begin
                            hi_d = sio_in;
                        end
                    end
                    if ((wr_q && slot_next == WR_SLOTS) || (!wr_q && slot_next == RD_SLOTS)) begin
                        state_d   = DESELECT;
                        ss_n_d    = 1'b1;
                        sio_oe_d  = 4'b0000;
                        sio_out_d = 4'b0000;
                        cnt_d     = 4'd0;
                    end else if (slot_next < 5'd8) begin
                        state_d   = CMD;
                        sio_out_d = {3'b000, opcode[~slot_next[2:0]]};
                        sio_oe_d  = 4'b0001;
                    end else if (slot_next < 5'd14) begin
                        state_d   = ADDR;
                        sio_out_d = addr_nibble(addr_q, slot_next);
                        sio_oe_d  = 4'b1111;
                    end else if (wr_q) begin
                        state_d   = WDATA;
                        sio_out_d = (slot_next == 5'd14) ? wdata_q[7:4] : wdata_q[3:0];
                        sio_oe_d  = 4'b1111;
                    end else if (slot_next < RDATA_FIRST) begin
                        state_d   = DUMMY;
                        sio_out_d = 4'b0000;
                        sio_oe_d  = 4'b0000;
                    end else begin
                        state_d   = RDATA;
                        sio_out_d = 4'b0000;
                        sio_oe_d  = 4'b0000;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= DESELECT;
            slot_q      <= 5'd0;
            cnt_q       <= 4'd0;
            sck_q       <= 1'b0;
            ss_n_q      <= 1'b1;
            sio_out_q   <= 4'b0000;
            sio_oe_q    <= 4'b0000;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            cnt_q       <= cnt_d;
            sck_q       <= sck_d;
            ss_n_q      <= ss_n_d;
            sio_out_q   <= sio_out_d;
            sio_oe_q    <= sio_oe_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Captured request fields and the high read nibble never need a reset value.
    always_ff @(posedge clk) begin
        hi_q    <= hi_d;
        wr_q    <= wr_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
    end

    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign sck       = sck_q;
    assign ss_n      = ss_n_q;
    assign sio_out   = sio_out_q;
    assign sio_oe    = sio_oe_q;

endmodule

// File: tb/tb_qspi_sram_controller.sv
// Bench for qspi_sram_controller: two instances (WAIT_CYCLES 4 and 6) share one SRAM model
// and one bus monitor through a select mux; directed vectors with hand-computed expectations.
module tb_qspi_sram_controller;

    localparam int DC = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b0;
    logic        rv = 1'b0;
    logic        rw = 1'b0;
    logic [23:0] ra = 24'h0;
    logic [7:0]  rd = 8'h0;
    logic [3:0]  sio_m = 4'h0;

    logic        rdy0, rdy1, rspv0, rspv1, sck0, sck1, ss0, ss1;
    logic [7:0]  rspd0, rspd1;
    logic [3:0]  out0, out1, oe0, oe1;

    logic        rdy_m, rspv_m, sck_m, ss_m;
    logic [7:0]  rspd_m;
    logic [3:0]  out_m, oe_m;

    assign rdy_m  = sel ? rdy1  : rdy0;
    assign rspv_m = sel ? rspv1 : rspv0;
    assign rspd_m = sel ? rspd1 : rspd0;
    assign sck_m  = sel ? sck1  : sck0;
    assign ss_m   = sel ? ss1   : ss0;
    assign out_m  = sel ? out1  : out0;
    assign oe_m   = sel ? oe1   : oe0;

    qspi_sram_controller #(.WAIT_CYCLES(4), .DESELECT_CYCLES(DC)) dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(rv & ~sel), .req_ready(rdy0),
        .req_write(rw), .req_addr(ra), .req_wdata(rd),
        .rsp_valid(rspv0), .rsp_rdata(rspd0), .sck(sck0), .ss_n(ss0),
        .sio_out(out0), .sio_oe(oe0), .sio_in(sio_m)
    );

    qspi_sram_controller #(.WAIT_CYCLES(6), .DESELECT_CYCLES(DC)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(rv & sel), .req_ready(rdy1),
        .req_write(rw), .req_addr(ra), .req_wdata(rd),
        .rsp_valid(rspv1), .rsp_rdata(rspd1), .sck(sck1), .ss_n(ss1),
        .sio_out(out1), .sio_oe(oe1), .sio_in(sio_m)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: 256 tagged byte slots (test addresses all differ in the low byte).
    logic [7:0]  mem [256];
    logic [23:0] tag [256];
    bit          vld [256];
    int          m_rises = 0;
    logic [7:0]  m_cmd = 8'h00;
    logic [23:0] m_addr = 24'h0;
    logic [7:0]  m_data = 8'h00;

    function automatic logic [7:0] mem_rd(input logic [23:0] a);
        return (vld[a[7:0]] && tag[a[7:0]] == a) ? mem[a[7:0]] : 8'h00;
    endfunction

    always @(posedge sck_m or posedge ss_m) begin
        if (ss_m) begin
            if (m_cmd == 8'h38 && m_rises == 16) begin
                mem[m_addr[7:0]] <= m_data;
                tag[m_addr[7:0]] <= m_addr;
                vld[m_addr[7:0]] <= 1'b1;
            end
            m_rises <= 0;
            m_cmd   <= 8'h00;
        end else begin
            m_rises <= m_rises + 1;
            if (m_rises < 8)
                m_cmd <= {m_cmd[6:0], out_m[0]};
            else if (m_rises < 14)
                m_addr <= {m_addr[19:0], out_m};
            else if (m_cmd == 8'h38)
                m_data <= {m_data[3:0], out_m};
            else if (m_cmd == 8'hEB && m_rises == 14 + (sel ? 6 : 4))
                sio_m <= 4'(mem_rd(m_addr) >> 4);
            else if (m_cmd == 8'hEB && m_rises == 15 + (sel ? 6 : 4))
                sio_m <= 4'(mem_rd(m_addr));
        end
    end

    // Bus monitor, sampled mid-cycle.
    int         acc_cyc = 0, rsp_cyc = 0, rsp_cnt = 0, done_cnt = 0, glitch = 0;
    int         rises = 0, low_cnt = 0, last_low = 0, last_rises = 0;
    logic [7:0] rsp_data = 8'h00;
    logic [3:0] log_out [32];
    logic [3:0] log_oe [32];
    logic       ss_prev = 1'b1, sck_prev = 1'b0;

    always @(negedge clk) begin
        if (rv && rdy_m) acc_cyc <= cyc;
        if (rspv_m) begin
            rsp_cnt  <= rsp_cnt + 1;
            rsp_cyc  <= cyc;
            rsp_data <= rspd_m;
        end
        if (sck_m && ss_m) glitch <= glitch + 1;
        if (!ss_m) begin
            low_cnt <= ss_prev ? 1 : low_cnt + 1;
            if (ss_prev) begin
                rises <= 0;
            end else if (sck_m && !sck_prev && rises < 32) begin
                log_out[rises] <= out_m;
                log_oe[rises]  <= oe_m;
                rises <= rises + 1;
            end
        end else if (!ss_prev) begin
            done_cnt   <= done_cnt + 1;
            last_low   <= low_cnt;
            last_rises <= rises;
        end
        ss_prev  <= ss_m;
        sck_prev <= sck_m;
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic do_req(input logic wr, input logic [23:0] a, input logic [7:0] d);
        bit ok;
        ok = 1'b0;
        @(posedge clk); #1;
        rv = 1'b1; rw = wr; ra = a; rd = d;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            if (rdy_m) ok = 1'b1;
        end
        @(posedge clk); #1;
        // Scramble the fields right after accept; the transaction must not notice.
        rv = 1'b0; rw = ~wr; ra = ~a; rd = ~d;
        if (!ok) check("accept_timeout", 0, 1);
    endtask

    task automatic wait_done(input string nm);
        int start;
        bit ok;
        start = done_cnt;
        ok = 1'b0;
        for (int n = 0; n < 400 && !ok; n++) begin
            @(negedge clk);
            if (done_cnt != start) ok = 1'b1;
        end
        if (!ok) check({nm, "_timeout"}, 0, 1);
    endtask

    task automatic release_reset(input string nm);
        int c0;
        bit seen;
        @(posedge clk); #1;
        rst_n = 1'b1;
        c0 = cyc;
        seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            if (rdy_m) begin
                seen = 1'b1;
                check(nm, cyc - c0, DC);
            end
        end
        if (!seen) check({nm, "_timeout"}, 0, 1);
    endtask

    typedef struct {
        int         idx;
        logic [3:0] out;
        logic [3:0] oe;
    } vec_t;

    vec_t        tbl [16];
    logic [23:0] b2b_addr [3];
    logic [7:0]  b2b_data [3];

    initial begin
        int rc, acc, run, maxrun, rsps, hi_run, gaps;
        logic prev_ss;

        // write 0x38 = 0011_1000 on sio[0], then A B C D E F (address) and C 3 (data)
        tbl[0]  = '{0,  4'h0, 4'h1};
        tbl[1]  = '{1,  4'h0, 4'h1};
        tbl[2]  = '{2,  4'h1, 4'h1};
        tbl[3]  = '{3,  4'h1, 4'h1};
        tbl[4]  = '{4,  4'h1, 4'h1};
        tbl[5]  = '{5,  4'h0, 4'h1};
        tbl[6]  = '{6,  4'h0, 4'h1};
        tbl[7]  = '{7,  4'h0, 4'h1};
        tbl[8]  = '{8,  4'hA, 4'hF};
        tbl[9]  = '{9,  4'hB, 4'hF};
        tbl[10] = '{10, 4'hC, 4'hF};
        tbl[11] = '{11, 4'hD, 4'hF};
        tbl[12] = '{12, 4'hE, 4'hF};
        tbl[13] = '{13, 4'hF, 4'hF};
        tbl[14] = '{14, 4'hC, 4'hF};
        tbl[15] = '{15, 4'h3, 4'hF};
        b2b_addr[0] = 24'h000010; b2b_data[0] = 8'h11;
        b2b_addr[1] = 24'h200020; b2b_data[1] = 8'h22;
        b2b_addr[2] = 24'h00ABCD; b2b_data[2] = 8'h3C;

        // Reset values
        #12;
        check("rst_sck", sck_m, 0);
        check("rst_ss_n", ss_m, 1);
        check("rst_sio_out", out_m, 0);
        check("rst_sio_oe", oe_m, 0);
        check("rst_rsp_valid", rspv_m, 0);
        check("rst_rsp_rdata", rspd_m, 0);
        check("rst_req_ready", rdy_m, 0);
        release_reset("ready_after_por");

        // Write 0x5A to 0x000123, then read it back (WAIT_CYCLES=4)
        rc = rsp_cnt;
        do_req(1'b1, 24'h000123, 8'h5A);
        wait_done("wr123");
        check("wr_ss_low_cycles", last_low, 32);
        check("wr_sck_rises", last_rises, 16);
        check("wr_no_rsp", rsp_cnt, rc);
        check("wr_mem_123", mem_rd(24'h000123), 8'h5A);
        do_req(1'b0, 24'h000123, 8'h00);
        wait_done("rd123");
        check("rd_latency", rsp_cyc - acc_cyc, 41);
        check("rd_data", rsp_data, 8'h5A);
        check("rd_rsp_count", rsp_cnt, rc + 1);
        check("rd_sck_rises", last_rises, 20);
        check("rd_ss_low_cycles", last_low, 40);

        // Bit-level write 0xC3 to 0xABCDEF
        do_req(1'b1, 24'hABCDEF, 8'hC3);
        wait_done("wrABCDEF");
        for (int i = 0; i < 16; i++) begin
            check($sformatf("bits_out_%0d", tbl[i].idx), log_out[tbl[i].idx], tbl[i].out);
            check($sformatf("bits_oe_%0d", tbl[i].idx), log_oe[tbl[i].idx], tbl[i].oe);
        end
        check("wr_mem_ABCDEF", mem_rd(24'hABCDEF), 8'hC3);
        check("rdata_held_after_write", rspd_m, 8'h5A);

        // WAIT_CYCLES=6 instance, address 0xFFFFFF
        sel = 1'b1;
        do_req(1'b1, 24'hFFFFFF, 8'h81);
        wait_done("wrFFFFFF");
        do_req(1'b0, 24'hFFFFFF, 8'h00);
        wait_done("rdFFFFFF");
        check("w6_sck_rises", last_rises, 22);
        check("w6_latency", rsp_cyc - acc_cyc, 45);
        check("w6_data", rsp_data, 8'h81);
        for (int k = 8; k < 14; k++)
            check($sformatf("w6_addr_nib_%0d", k), log_out[k], 4'hF);
        for (int k = 14; k < 22; k++)
            check($sformatf("w6_oe_off_%0d", k), log_oe[k], 4'h0);
        sel = 1'b0;

        // Back-to-back reads with req_valid held high
        for (int i = 0; i < 3; i++) begin
            do_req(1'b1, b2b_addr[i], b2b_data[i]);
            wait_done("b2b_fill");
        end
        @(posedge clk); #1;
        rv = 1'b1; rw = 1'b0; ra = b2b_addr[0];
        acc = 0; run = 0; maxrun = 0; rsps = 0; hi_run = 0; gaps = 0; prev_ss = 1'b1;
        for (int n = 0; n < 400 && rsps < 3; n++) begin
            @(negedge clk);
            run = rdy_m ? run + 1 : 0;
            if (run > maxrun) maxrun = run;
            if (ss_m) begin
                hi_run++;
            end else begin
                // Gap = DESELECT cycles plus the single IDLE cycle in which the next request is accepted.
                if (prev_ss && acc >= 2) begin
                    check($sformatf("b2b_gap_%0d", gaps), hi_run, DC + 1);
                    gaps++;
                end
                hi_run = 0;
            end
            prev_ss = ss_m;
            if (rspv_m) begin
                if (rsps < 3) check($sformatf("b2b_data_%0d", rsps), rspd_m, b2b_data[rsps]);
                rsps++;
            end
            if (rv && rdy_m) begin
                acc++;
                @(posedge clk); #1;
                if (acc < 3) ra = b2b_addr[acc];
                else rv = 1'b0;
            end
        end
        rv = 1'b0;
        check("b2b_rsp_count", rsps, 3);
        check("b2b_gap_count", gaps, 2);
        check("b2b_ready_run", maxrun, 1);
        wait_done("b2b_last");

        // Reset in the middle of a read
        rc = rsp_cnt;
        do_req(1'b0, 24'h000123, 8'h00);
        for (int n = 0; n < 40 && cyc < acc_cyc + 20; n++) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_ss_n", ss_m, 1);
        check("abort_sck", sck_m, 0);
        check("abort_sio_oe", oe_m, 0);
        check("abort_rdata", rspd_m, 0);
        repeat (2) @(posedge clk);
        release_reset("ready_after_abort");
        check("abort_no_rsp", rsp_cnt, rc);
        do_req(1'b0, 24'h000123, 8'h00);
        wait_done("rd_after_abort");
        check("post_abort_data", rsp_data, 8'h5A);
        check("post_abort_latency", rsp_cyc - acc_cyc, 41);

        // Captured fields: the inputs are inverted right after accept
        do_req(1'b1, 24'h000321, 8'h77);
        wait_done("wr321");
        check("capture_wdata", mem_rd(24'h000321), 8'h77);
        check("capture_no_stray", 32'(vld[8'hDE]), 0);
        do_req(1'b0, 24'h000321, 8'h00);
        wait_done("rd321");
        check("capture_read", rsp_data, 8'h77);

        check("sck_low_when_deselected", glitch, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
